rs_issue_select: RTL

RS_ISSUE_SELECT -- requirements
Module: rs_issue_select

---
 rtl/rs_issue_select.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/rs_issue_select.sv
// Reservation station with tag wakeup, age-matrix oldest-first select and a one-entry issue register.
// Optional flush port and logic are enabled by defining RS_FLUSH_EN.
package rs_issue_pkg;
    typedef enum logic [3:0] {
        INVALID_I = 4'd0,
        ADD_I,
        SUB_I,
        AND_I,
        OR_I,
        XOR_I,
        LD_I,
        ST_I,
        BR_I
    } instr_opcode;
endpackage

module rs_issue_select
    import rs_issue_pkg::*;
#(
    parameter int RS_ENTRIES = 8,
    parameter int NUM_FUS    = 4,
    parameter int NUM_PREGS  = 128,
    localparam int PREG_W    = $clog2(NUM_PREGS),
    localparam int OCC_W     = $clog2(RS_ENTRIES + 1),
    localparam int IDX_W     = (RS_ENTRIES > 1) ? $clog2(RS_ENTRIES) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
`ifdef RS_FLUSH_EN
    input  logic                        flush,
`endif
    input  logic                        disp_valid,
    output logic                        disp_ready,
    input  instr_opcode                 disp_opcode,
    input  logic [PREG_W-1:0]           disp_src1_index,
    input  logic [PREG_W-1:0]           disp_src2_index,
    input  logic                        disp_src1_rdy,
    input  logic                        disp_src2_rdy,
    input  logic [PREG_W-1:0]           disp_dest,
    input  logic [31:0]                 disp_imm_val,
    input  logic [NUM_FUS-1:0]          wb_valid,
    input  logic [NUM_FUS*PREG_W-1:0]   wb_tag,
    output logic                        iss_valid,
    input  logic                        iss_ready,
    output instr_opcode                 iss_opcode,
    output logic [PREG_W-1:0]           iss_src1_index,
    output logic [PREG_W-1:0]           iss_src2_index,
    output logic [31:0]                 iss_imm_val,
    output logic [PREG_W-1:0]           iss_dest,
    output logic [OCC_W-1:0]            occupancy
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
    // valid and payload stay stable until that edge, ready never depends on valid.
    logic [RS_ENTRIES-1:0] ent_valid;
    logic [RS_ENTRIES-1:0] ent_rdy1;
    logic [RS_ENTRIES-1:0] ent_rdy2;
    instr_opcode           ent_op   [RS_ENTRIES];
    logic [PREG_W-1:0]     ent_src1 [RS_ENTRIES];
    logic [PREG_W-1:0]     ent_src2 [RS_ENTRIES];
    logic [PREG_W-1:0]     ent_dest [RS_ENTRIES];
    logic [31:0]           ent_imm  [RS_ENTRIES];
    // older[i][j] is 1 when entry i was dispatched before entry j.
    logic [RS_ENTRIES-1:0] older    [RS_ENTRIES];

    logic [RS_ENTRIES-1:0] ent_hit1, ent_hit2;
    logic                  disp_hit1, disp_hit2;
    logic [OCC_W-1:0]      occ_cnt;
    logic                  free_found;
    logic [IDX_W-1:0]      free_idx;
    logic [RS_ENTRIES-1:0] elig;
    logic [RS_ENTRIES-1:0] sel_oh;
    logic [IDX_W-1:0]      sel_idx;
    logic                  any_elig;
    logic                  iss_free;
    logic                  issue_take;
    logic                  disp_fire;
    logic                  blocked;

    always_comb begin
        ent_hit1  = '0;
        ent_hit2  = '0;
        disp_hit1 = 1'b0;
        disp_hit2 = 1'b0;
        for (int f = 0; f < NUM_FUS; f++) begin
            if (wb_valid[f]) begin
                if (wb_tag[f*PREG_W +: PREG_W] == disp_src1_index) disp_hit1 = 1'b1;
                if (wb_tag[f*PREG_W +: PREG_W] == disp_src2_index) disp_hit2 = 1'b1;
                for (int i = 0; i < RS_ENTRIES; i++) begin
                    if (wb_tag[f*PREG_W +: PREG_W] == ent_src1[i]) ent_hit1[i] = 1'b1;
                    if (wb_tag[f*PREG_W +: PREG_W] == ent_src2[i]) ent_hit2[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        occ_cnt    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            occ_cnt = occ_cnt + OCC_W'(ent_valid[i]);
            if (!ent_valid[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign occupancy  = occ_cnt;
    assign disp_ready = (occ_cnt < OCC_W'(RS_ENTRIES));
    assign disp_fire  = disp_valid && disp_ready && free_found;

    // An entry wins when it is eligible and no other eligible entry is older.
    assign elig = ent_valid & ent_rdy1 & ent_rdy2;

    always_comb begin
        sel_oh  = '0;
        sel_idx = '0;
        blocked = 1'b0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            blocked = 1'b0;
            for (int j = 0; j < RS_ENTRIES; j++) begin
                if (elig[j] && older[j][i]) blocked = 1'b1;
            end
            sel_oh[i] = elig[i] && !blocked;
            if (sel_oh[i]) sel_idx = IDX_W'(i);
        end
    end

    assign any_elig   = |elig;
    assign iss_free   = !iss_valid || iss_ready;
    assign issue_take = iss_free && any_elig;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_valid <= '0;
            ent_rdy1  <= '0;
            ent_rdy2  <= '0;
            for (int i = 0; i < RS_ENTRIES; i++) begin
                ent_op[i]   <= INVALID_I;
                ent_src1[i] <= '0;
                ent_src2[i] <= '0;
                ent_dest[i] <= '0;
                ent_imm[i]  <= '0;
                older[i]    <= '0;
            end
        end else
`ifdef RS_FLUSH_EN
        if (flush) begin
            ent_valid <= '0;
        end else
`endif
        begin
            ent_rdy1 <= ent_rdy1 | ent_hit1;
            ent_rdy2 <= ent_rdy2 | ent_hit2;
            if (issue_take) begin
                ent_valid[sel_idx] <= 1'b0;
            end
            if (disp_fire) begin
                ent_valid[free_idx] <= 1'b1;
                ent_rdy1[free_idx]  <= disp_src1_rdy | disp_hit1;
                ent_rdy2[free_idx]  <= disp_src2_rdy | disp_hit2;
                ent_op[free_idx]    <= disp_opcode;
                ent_src1[free_idx]  <= disp_src1_index;
                ent_src2[free_idx]  <= disp_src2_index;
                ent_dest[free_idx]  <= disp_dest;
                ent_imm[free_idx]   <= disp_imm_val;
                // New entry is younger than every entry currently held.
                for (int j = 0; j < RS_ENTRIES; j++) begin
                    older[free_idx][j] <= 1'b0;
                    older[j][free_idx] <= ent_valid[j];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid      <= 1'b0;
            iss_opcode     <= INVALID_I;
            iss_src1_index <= '0;
            iss_src2_index <= '0;
            iss_imm_val    <= '0;
            iss_dest       <= '0;
        end else
`ifdef RS_FLUSH_EN
        if (flush) begin
            iss_valid <= 1'b0;
        end else
`endif
        if (iss_free) begin
            iss_valid <= any_elig;
            if (any_elig) begin
                iss_opcode     <= ent_op[sel_idx];
                iss_src1_index <= ent_src1[sel_idx];
                iss_src2_index <= ent_src2[sel_idx];
                iss_imm_val    <= ent_imm[sel_idx];
                iss_dest       <= ent_dest[sel_idx];
            end
        end
    end

endmodule
